fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Circular bundle FIFO between instruction fetch/align and `instr_decode`.
- Each entry is one fetch bundle: a PC base plus `FETCH_WIDTH` `aligned_instr_t` lanes.
- Absorbs fetch/decode rate mismatch, presents the head bundle directly on the decode input ports, and honours decode stall and pipeline flush.

Parameters:
- DEPTH, 4, number of bundle entries; power of two, >= 2.
- FETCH_WIDTH, `FETCH_WIDTH` (2), lanes per bundle.
- VADDR_WIDTH, `VADDR_WIDTH` (32), PC width.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_enq_valid  input  1  fetch presents a bundle this cycle.
- i_enq_pc_base  input  VADDR_WIDTH  bundle PC base; bits [2:0] ignored.
- i_enq_instrs  input  aligned_instr_t x FETCH_WIDTH  fetched lanes (valid, pc_offset, instr).
- o_enq_ready  output  1  queue can accept a bundle this cycle.
- o_pc_base  output  VADDR_WIDTH  head bundle PC base, to decode i_pc_base.
- o_instrs  output  aligned_instr_t x FETCH_WIDTH  head bundle lanes, to decode i_instrs.
- i_stall  input  1  decode (or later stage) cannot consume the head this cycle.
- i_flush  input  1  redirect; discard all queued bundles.
- o_count  output  $clog2(DEPTH)+1  occupied entries, for perf counters and debug.

Behaviour:
- State:
  - storage array of DEPTH entries {pc_base, lanes}
  - head_ptr and tail_ptr, $clog2(DEPTH) bits, wrap modulo DEPTH
  - count, 0..DEPTH
- Reset (async, i_rst=1): head_ptr=0, tail_ptr=0, count=0. Outputs: o_enq_ready=1, o_count=0, o_pc_base=0, all o_instrs fields=0. Storage contents are don't-care.
- o_enq_ready = (count != DEPTH). It is registered-state based only and does not depend on the same-cycle dequeue (no full-bypass).
- enq_fire = i_enq_valid & o_enq_ready & ~i_flush & (|lane valid bits).
  - A bundle with all lane valid bits 0 is accepted but not stored.
- On enq_fire: write storage[tail_ptr]; tail_ptr += 1 (wraps DEPTH-1 -> 0).
- Head presentation:
  - empty = (count == 0).
  - o_pc_base = storage[head_ptr].pc_base, and o_instrs = storage[head_ptr].lanes, when ~empty & ~i_flush.
  - Otherwise o_instrs is all zeros (valid=0) and o_pc_base=0.
  - Combinational read; no bypass from enqueue. Minimum latency from enq_fire to appearance on o_instrs is 1 cycle.
- deq_fire = ~empty & ~i_stall & ~i_flush. On deq_fire: head_ptr += 1 (wraps).
- count update:
  - count + enq_fire - deq_fire.
  - Simultaneous enqueue and dequeue keeps count unchanged.
  - When count == DEPTH, a same-cycle dequeue does not allow a same-cycle enqueue.
- Flush:
  - In the flush cycle: o_instrs valid bits are forced 0, and no enqueue or dequeue occurs.
  - Next edge: head_ptr=0, tail_ptr=0, count=0.
  - i_flush has priority over i_enq_valid and i_stall.
- Stall: the head holds, and o_pc_base/o_instrs are stable while i_stall=1, count>0, i_flush=0.
- o_count = count.
- Lane contiguity: a stored bundle must have lane valid bits contiguous from lane 0. A bundle with lane 1 valid and lane 0 invalid triggers a simulation $error; it is stored unchanged.
- Reset asserted mid-operation: all queued bundles are lost; the state equals the reset state asynchronously.

Test Plan:
- Reset, then enqueue pc_base=0x1000 with lanes {valid=1, off=0, instr=0x00000013} and {valid=1, off=4, instr=0x00100093}, i_stall=0 -> next cycle o_pc_base=0x1000, both lanes valid with those values; the following cycle o_instrs valid=0 and o_count=0.
- Hold i_stall=1 and enqueue 4 bundles (pc 0x0, 0x8, 0x10, 0x18) -> o_count reaches 4, o_enq_ready=0, a 5th bundle (0x20) is not accepted, and the head stays 0x0. Release the stall -> the heads appear in order 0x0, 0x8, 0x10, 0x18, one per cycle.
- Wrap-around: sustain 10 enqueues with continuous dequeue at count=1 -> pointers wrap past 3, and PC order is preserved (0x0..0x48 step 8).
- At count=3, assert i_flush together with i_enq_valid -> o_instrs valid=0 that cycle; next cycle o_count=0, o_enq_ready=1, and the flushed-cycle bundle is absent.
- At count=4 with i_stall=0 and i_enq_valid=1 -> the head dequeues but the enqueue is rejected; next cycle o_count=3 and o_enq_ready=1.
- Enqueue an all-invalid bundle -> o_count stays 0. Assert i_rst mid-stream at count=2 -> o_count=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue (plus fetch_queue_pkg)
// Brief    : Circular FIFO of fetch bundles between fetch/align and decode.
//            Each entry holds a PC base and FETCH_WIDTH aligned lanes. The
//            head entry is driven combinationally onto the decode inputs.
//            The queue honours decode stall and pipeline flush.
// Ports    : i_clk, i_rst (async, active-high)
//            i_enq_valid, i_enq_pc_base, i_enq_instrs -> o_enq_ready
//            o_pc_base, o_instrs (head bundle), i_stall, i_flush
//            o_count (occupancy)
// Revision : 1.0 - initial release
// ============================================================================

package fetch_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [2:0]  pc_offset;
        logic [31:0] instr;
    } aligned_instr_t;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FETCH_WIDTH = 2,
    parameter int VADDR_WIDTH = 32
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_enq_valid,
    input  logic [VADDR_WIDTH-1:0]              i_enq_pc_base,
    input  aligned_instr_t [FETCH_WIDTH-1:0]    i_enq_instrs,
    output logic                                o_enq_ready,
    output logic [VADDR_WIDTH-1:0]              o_pc_base,
    output aligned_instr_t [FETCH_WIDTH-1:0]    o_instrs,
    input  logic                                i_stall,
    input  logic                                i_flush,
    output logic [$clog2(DEPTH):0]              o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    // PC base low bits are not meaningful for a bundle; they are stored as 0.
    localparam logic [VADDR_WIDTH-1:0] c_pc_mask = ~VADDR_WIDTH'(7);

    logic [VADDR_WIDTH-1:0]           r_pc_mem [DEPTH];
    aligned_instr_t [FETCH_WIDTH-1:0] r_lane_mem [DEPTH];
    logic [c_ptr_w-1:0]               r_head_ptr;
    logic [c_ptr_w-1:0]               r_tail_ptr;
    logic [c_cnt_w-1:0]               r_count;

    logic w_empty;
    logic w_any_valid;
    logic w_enq_fire;
    logic w_deq_fire;

    always_comb begin
        w_any_valid = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_any_valid = w_any_valid | i_enq_instrs[i].valid;
        end
    end

    // Ready looks only at registered occupancy: a full queue refuses an
    // enqueue even while the head is leaving in the same cycle.
    assign o_enq_ready = (r_count != c_cnt_w'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_enq_fire  = i_enq_valid & o_enq_ready & ~i_flush & w_any_valid;
    assign w_deq_fire  = ~w_empty & ~i_stall & ~i_flush;
    assign o_count     = r_count;

    always_comb begin
        o_pc_base = '0;
        o_instrs  = '0;
        if (!w_empty && !i_flush) begin
            o_pc_base = r_pc_mem[r_head_ptr];
            o_instrs  = r_lane_mem[r_head_ptr];
        end
    end

    // Storage carries no reset; its contents are only observed when counted.
    always_ff @(posedge i_clk) begin
        if (w_enq_fire) begin
            r_pc_mem[r_tail_ptr]   <= i_enq_pc_base & c_pc_mask;
            r_lane_mem[r_tail_ptr] <= i_enq_instrs;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else if (i_flush) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail_ptr <= r_tail_ptr + 1'b1;
            end
            if (w_deq_fire) begin
                r_head_ptr <= r_head_ptr + 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_enq_fire) - c_cnt_w'(w_deq_fire);
        end
    end

`ifndef SYNTHESIS
    // Decode assumes valid lanes are packed from lane 0 upward.
    always @(posedge i_clk) begin
        if (!i_rst && w_enq_fire) begin
            for (int i = 1; i < FETCH_WIDTH; i++) begin
                if (i_enq_instrs[i].valid && !i_enq_instrs[i-1].valid) begin
                    $error("fetch_queue: non-contiguous lane valid bits at lane %0d", i);
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed self-checking bench for fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int c_depth = 4;
    localparam int c_fw    = 2;
    localparam int c_vw    = 32;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         enq_valid;
    logic [c_vw-1:0]              enq_pc_base;
    aligned_instr_t [c_fw-1:0]    enq_instrs;
    logic                         enq_ready;
    logic [c_vw-1:0]              pc_base;
    aligned_instr_t [c_fw-1:0]    instrs;
    logic                         stall;
    logic                         flush;
    logic [$clog2(c_depth):0]     count;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_queue #(
        .DEPTH       (c_depth),
        .FETCH_WIDTH (c_fw),
        .VADDR_WIDTH (c_vw)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enq_valid   (enq_valid),
        .i_enq_pc_base (enq_pc_base),
        .i_enq_instrs  (enq_instrs),
        .o_enq_ready   (enq_ready),
        .o_pc_base     (pc_base),
        .o_instrs      (instrs),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Generic bundle: instr words derived from the PC so every bundle differs.
    function automatic logic [2*36-1:0] mk(input logic [31:0] pc, input logic v0, input logic v1);
        aligned_instr_t [1:0] l;
        l[0].valid = v0; l[0].pc_offset = 3'd0; l[0].instr = 32'h0000_0013 + pc;
        l[1].valid = v1; l[1].pc_offset = 3'd4; l[1].instr = 32'h0000_0093 + pc;
        return l;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic v0, input logic v1);
        enq_valid   = v;
        enq_pc_base = pc;
        enq_instrs  = mk(pc, v0, v1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_pc"}, 128'(pc_base), 128'(pc));
        chk({tag, "_lanes"}, 128'(instrs), 128'(mk(pc, 1'b1, 1'b1)));
    endtask

    initial begin
        aligned_instr_t [1:0] first;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_ready", 128'(enq_ready), 128'(1));
        chk("rst_pc", 128'(pc_base), 128'(0));
        chk("rst_instrs", 128'(instrs), 128'(0));
        tick(); tick();
        rst = 1'b0;

        // Single bundle passes straight through with one cycle latency.
        first[0].valid = 1'b1; first[0].pc_offset = 3'd0; first[0].instr = 32'h0000_0013;
        first[1].valid = 1'b1; first[1].pc_offset = 3'd4; first[1].instr = 32'h0010_0093;
        enq_valid = 1'b1; enq_pc_base = 32'h1000; enq_instrs = first;
        chk("t1_not_bypassed", 128'(instrs), 128'(0));
        tick();
        enq_valid = 1'b0;
        chk("t1_pc", 128'(pc_base), 128'(32'h1000));
        chk("t1_lanes", 128'(instrs), 128'(first));
        chk("t1_count1", 128'(count), 128'(1));
        tick();
        chk("t1_drained", 128'(instrs), 128'(0));
        chk("t1_count0", 128'(count), 128'(0));

        // Fill under stall, fifth bundle refused, then drain in order.
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(k * 8), 1'b1, 1'b1);
            tick();
        end
        chk("full_count", 128'(count), 128'(4));
        chk("full_ready", 128'(enq_ready), 128'(0));
        drive(1'b1, 32'h20, 1'b1, 1'b1);
        tick();
        chk("full_reject_count", 128'(count), 128'(4));
        chk_head("full_head_hold", 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        stall = 1'b0;
        #1;
        chk_head("drain0", 32'h0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_head("drain", 32'(k * 8));
        end
        tick();
        chk("drain_empty", 128'(count), 128'(0));
        chk("drain_no_0x20", 128'(instrs), 128'(0));

        // Wrap-around with continuous enqueue and dequeue at count=1.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(k * 8), 1'b1, 1'b1);
            tick();
            chk_head("wrap", 32'(k * 8));
            chk("wrap_count", 128'(count), 128'(1));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("wrap_empty", 128'(count), 128'(0));

        // Flush at count=3 with a concurrent enqueue.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h100 + 32'(k * 8), 1'b1, 1'b1);
            tick();
        end
        chk("pre_flush_count", 128'(count), 128'(3));
        flush = 1'b1;
        drive(1'b1, 32'h118, 1'b1, 1'b1);
        #1;
        chk("flush_instrs", 128'(instrs), 128'(0));
        chk("flush_pc", 128'(pc_base), 128'(0));
        tick();
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("post_flush_count", 128'(count), 128'(0));
        chk("post_flush_ready", 128'(enq_ready), 128'(1));
        chk("post_flush_absent", 128'(instrs), 128'(0));
        drive(1'b1, 32'h200, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_head("post_flush_enq", 32'h200);
        tick();
        chk("post_flush_drain", 128'(count), 128'(0));

        // Full queue: dequeue happens, same-cycle enqueue rejected.
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h300 + 32'(k * 8), 1'b1, 1'b1);
            tick();
        end
        stall = 1'b0;
        drive(1'b1, 32'h320, 1'b1, 1'b1);
        #1;
        chk("fd_ready0", 128'(enq_ready), 128'(0));
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fd_count3", 128'(count), 128'(3));
        chk("fd_ready1", 128'(enq_ready), 128'(1));
        chk_head("fd_head", 32'h308);
        tick();
        chk_head("fd_head", 32'h310);
        tick();
        chk_head("fd_head", 32'h318);
        tick();
        chk("fd_no_0x320", 128'(count), 128'(0));

        // All-invalid bundle is accepted but not stored.
        drive(1'b1, 32'h400, 1'b0, 1'b0);
        #1;
        chk("inv_ready", 128'(enq_ready), 128'(1));
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("inv_count", 128'(count), 128'(0));

        // Single-lane bundle keeps lane 1 invalid.
        drive(1'b1, 32'h500, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("one_lane", 128'(instrs), 128'(mk(32'h500, 1'b1, 1'b0)));
        tick();

        // Asynchronous reset mid-stream at count=2.
        stall = 1'b1;
        drive(1'b1, 32'h600, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h608, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_count", 128'(count), 128'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 128'(count), 128'(0));
        chk("async_rst_ready", 128'(enq_ready), 128'(1));
        chk("async_rst_instrs", 128'(instrs), 128'(0));
        #2;
        rst = 1'b0;
        stall = 1'b0;
        tick();
        chk("after_rst_count", 128'(count), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
